// File: rtl/data_sram_arbiter.sv
// Data-SRAM port arbiter: NUM_CH requesters share one synchronous-read SRAM, one grant per cycle.
// Latency: SRAM is driven combinationally in the grant cycle; rsp_valid/rsp_rdata follow exactly 1 cycle later.
// Backpressure: req_ready is the grant (one-hot or zero); responses cannot be stalled by the consumer.
// Ports: clk/resetn; req_valid/req_ready/req_we/req_addr/req_wdata are per-channel request slices;
//   flush cancels a channel's request and pending ack; rsp_valid/rsp_rdata return acks and read data;
//   sram_en/we/addr/wdata/rdata form the single SRAM port.
module data_sram_arbiter #(
  parameter int NUM_CH       = 2,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int RR_MODE      = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [NUM_CH-1:0]            req_valid,
  output logic [NUM_CH-1:0]            req_ready,
  input  logic [NUM_CH*(DATA_W/8)-1:0] req_we,
  input  logic [NUM_CH*ADDR_W-1:0]     req_addr,
  input  logic [NUM_CH*DATA_W-1:0]     req_wdata,
  input  logic [NUM_CH-1:0]            flush,
  output logic [NUM_CH-1:0]            rsp_valid,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic                         sram_en,
  output logic [DATA_W/8-1:0]          sram_we,
  output logic [ADDR_W-1:0]            sram_addr,
  output logic [DATA_W-1:0]            sram_wdata,
  input  logic [DATA_W-1:0]            sram_rdata
);

  localparam int BE_W = DATA_W / 8;
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] w_elig;
  logic              w_gnt_vld;
  logic [CH_W-1:0]   w_gnt_idx;
  logic [NUM_CH-1:0] w_gnt_oh;

  logic [CH_W-1:0]   r_ptr;
  logic              r_pend;
  logic              r_pend_rd;
  logic [CH_W-1:0]   r_pend_ch;
  logic [7:0]        r_starve [NUM_CH];

  // Arbitration: a flushed channel is simply not eligible, so the others compete in the same cycle.
  always_comb begin : arb
    int c;
    c         = 0;
    w_elig    = req_valid & ~flush;
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    if (RR_MODE != 0) begin
      // Search starts just past the last winner and wraps.
      for (int k = 1; k <= NUM_CH; k++) begin
        c = int'(r_ptr) + k;
        if (c >= NUM_CH) c = c - NUM_CH;
        if (!w_gnt_vld && w_elig[c]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = CH_W'(c);
        end
      end
    end else begin
      // A starved channel overrides plain priority; lowest index wins among starved ones.
      for (int i = 0; i < NUM_CH; i++) begin
        if (!w_gnt_vld && w_elig[i] && (r_starve[i] == 8'(STARVE_LIMIT))) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = CH_W'(i);
        end
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (!w_gnt_vld && w_elig[i]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = CH_W'(i);
        end
      end
    end
    // No grants while reset is held, even though the inputs may be active.
    if (!resetn) w_gnt_vld = 1'b0;
    w_gnt_oh = '0;
    if (w_gnt_vld) w_gnt_oh[w_gnt_idx] = 1'b1;
  end

  always_comb begin : drive
    req_ready  = w_gnt_oh;
    sram_en    = w_gnt_vld;
    sram_we    = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (w_gnt_vld) begin
      sram_we    = req_we[int'(w_gnt_idx)*BE_W +: BE_W];
      sram_addr  = req_addr[int'(w_gnt_idx)*ADDR_W +: ADDR_W];
      sram_wdata = req_wdata[int'(w_gnt_idx)*DATA_W +: DATA_W];
    end
    // A flush in the response cycle only hides the ack; a write already issued has landed.
    rsp_valid = '0;
    rsp_rdata = '0;
    if (r_pend && !flush[r_pend_ch]) begin
      rsp_valid[r_pend_ch] = 1'b1;
      if (r_pend_rd) rsp_rdata = sram_rdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ptr     <= CH_W'(NUM_CH - 1);
      r_pend    <= 1'b0;
      r_pend_rd <= 1'b0;
      r_pend_ch <= '0;
      for (int i = 0; i < NUM_CH; i++) r_starve[i] <= '0;
    end else begin
      r_pend    <= w_gnt_vld;
      r_pend_ch <= w_gnt_idx;
      r_pend_rd <= ~|sram_we;
      if ((RR_MODE != 0) && w_gnt_vld) r_ptr <= w_gnt_idx;
      for (int i = 0; i < NUM_CH; i++) begin
        if ((RR_MODE == 0) && w_elig[i] && !w_gnt_oh[i]) begin
          if (r_starve[i] != 8'(STARVE_LIMIT)) r_starve[i] <= r_starve[i] + 8'd1;
        end else begin
          r_starve[i] <= '0;
        end
      end
    end
  end

endmodule

// File: doc/data_sram_arbiter.md
Name: data_sram_arbiter

Overview:
Parametrised data-SRAM port arbiter for the five-stage core.
- Replaces the hard-wired "store in MEM beats load in ID" mux with N requester channels (e.g. ID load, MEM store, future cache/DMA refill) sharing one synchronous-read data SRAM.
- Grants one request per cycle using round-robin or starvation-protected fixed priority.
- Returns a per-channel response pulse one cycle after the grant, with a per-channel flush for branch or exception cancel.

Parameters:
- NUM_CH, 2, number of requester channels (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte-enable width BE_W = DATA_W/8.
- RR_MODE, 1, 1 = round-robin, 0 = fixed priority (channel 0 highest) with starvation override.
- STARVE_LIMIT, 8, fixed mode only: number of consecutive waiting cycles after which a channel is forced (1..255).

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  NUM_CH  per-channel request valid.
- req_ready  out  NUM_CH  per-channel grant; handshake fires when valid & ready.
- req_we  in  NUM_CH*BE_W  byte write enables; all zero means read.
- req_addr  in  NUM_CH*ADDR_W  byte address.
- req_wdata  in  NUM_CH*DATA_W  write data.
- flush  in  NUM_CH  cancel a channel's request and its pending response.
- rsp_valid  out  NUM_CH  one-cycle response pulse, read or write ack.
- rsp_rdata  out  DATA_W  read data, shared by all channels.
- sram_en  out  1  SRAM enable.
- sram_we  out  BE_W  SRAM byte write enables.
- sram_addr  out  ADDR_W  SRAM address.
- sram_wdata  out  DATA_W  SRAM write data.
- sram_rdata  in  DATA_W  SRAM read data, valid the cycle after sram_en.

Behaviour:
Reset
- While resetn = 0, all outputs are 0.
- RR pointer resets to NUM_CH-1, so channel 0 wins first.
- Starvation counters and the pending-response register reset to 0.
- A reset asserted mid-operation drops any pending response; no rsp_valid is issued after reset is released.

Eligibility and grant
- Channel i is eligible when req_valid[i] & ~flush[i].
- req_ready is combinational from the current eligible set and state. It is one-hot or zero, and never asserted for an ineligible channel.
- A fire occurs on req_valid[i] & req_ready[i].

RR_MODE = 1
- Search starts at pointer+1 and wraps modulo NUM_CH. The first eligible channel is granted.
- On a fire, pointer <= granted index. With no fire, the pointer holds.

RR_MODE = 0
- Per-channel counter starve[i] (8 bits): increments while eligible and not granted, saturating at STARVE_LIMIT.
- starve[i] clears when channel i is granted or is not eligible.
- If any eligible channel has starve == STARVE_LIMIT, the lowest-index such channel wins. Otherwise the lowest-index eligible channel wins.
- In RR mode the counters are held at 0.

SRAM drive (same cycle as fire, combinational)
- sram_en = 1.
- sram_we, sram_addr, sram_wdata come from the granted channel's slice.
- With no fire: sram_en = 0, sram_we = 0, sram_addr = 0, sram_wdata = 0.

Response pipeline
- On a fire, register pend = 1 and pend_ch = granted index; otherwise pend = 0.
- In the next cycle, rsp_valid[pend_ch] = pend & ~flush[pend_ch]. All other rsp_valid bits are 0.
- Latency is exactly 1 cycle. Responses have no backpressure; the consumer must accept them.
- rsp_rdata = sram_rdata when the response is a non-flushed read, else 0.
- Writes that have already fired still complete in the SRAM even if flushed; only their ack is suppressed.

Throughput and simultaneous events
- Back-to-back fires are allowed, one per cycle, so full throughput is 1 request/cycle.
- A response for one channel and a new grant to the same channel may occur in the same cycle.
- All channels valid: RR mode serves 0,1,..,N-1,0,... Fixed mode serves channel 0 until some other channel's starve reaches STARVE_LIMIT.
- A flush asserted in the grant cycle blocks that channel's grant; arbitration proceeds among the other eligible channels in the same cycle.

Test Plan:
- Reset: hold resetn = 0 with all req_valid = 1 → req_ready = 0, sram_en = 0, rsp_valid = 0. Release → channel 0 is granted in the first cycle.
- RR, NUM_CH = 3, all channels valid for 6 cycles → grants 0,1,2,0,1,2. rsp_valid is one-hot and lags each grant by 1 cycle.
- Read: ch1 reads addr 0x1000 with the SRAM returning 0xDEADBEEF → next cycle rsp_valid = 3'b010, rsp_rdata = 0xDEADBEEF. Ch0 write we = 4'b0011 in the same window → sram_we = 4'b0011 with ch0 addr/wdata.
- Fixed mode, STARVE_LIMIT = 4, ch0 and ch1 both continuously valid → ch0 granted 4 cycles, ch1 granted in the 5th, then ch0 resumes.
- Flush: ch1 read fires, flush[1] = 1 in the response cycle → rsp_valid[1] = 0, rsp_rdata = 0. flush[0] = 1 with req_valid[0] = 1 → ch0 not granted, ch1 granted instead.
- Reset mid-operation: resetn falls in the cycle after a fire → no rsp_valid is issued; after release the RR pointer restarts at channel 0.
